wb_test_slave: RTL and testbench

//  Synthesizable classic (non-pipelined) Wishbone slave; consumes the bus driven by the

---
 rtl/wb_test_slave.sv | 135 +++++++++++++
 tb/tb_wb_test_slave.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/wb_test_slave.sv
// wb_test_slave: classic Wishbone slave with byte-writable scratch RAM,
// programmable ack wait states and RAM access counters.
module wb_test_slave #(
    parameter int          ADDR_BITS    = 8,
    parameter logic [31:0] ID_VALUE     = 32'h05B5_0001,
    parameter int          DEFAULT_WAIT = 0
) (
    input  logic        wb_clk,
    input  logic        wb_rst_n,
    input  logic [31:0] wb_addr,
    input  logic [31:0] wb_data_i,
    output logic [31:0] wb_data_o,
    input  logic [3:0]  wb_bwsel,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    output logic        wb_ack
);
    localparam logic [3:0] WAIT_RST = 4'(DEFAULT_WAIT);

    typedef enum logic [1:0] {IDLE, WAIT, ACK, DONE} state_t;

    state_t             state_q, state_d;
    logic [ADDR_BITS:0] addr_q, addr_d;
    logic               we_q, we_d;
    logic [31:0]        dat_q, dat_d;
    logic [3:0]         sel_q, sel_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [3:0]         wcfg_q, wcfg_d;
    logic [31:0]        wr_cnt_q, wr_cnt_d;
    logic [31:0]        rd_cnt_q, rd_cnt_d;
    logic               ack_q, ack_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [31:0] mem [2**ADDR_BITS];

    logic                 req, idle, go_ack, is_ctrl, acc_we, ram_wr, ram_rd;
    logic [ADDR_BITS:0]   acc_addr;
    logic [ADDR_BITS-1:0] ram_idx;
    logic [1:0]           reg_sel;
    logic [31:0]          acc_dat, ctrl_val, rd_val;
    logic [3:0]           acc_sel;
    logic                 unused_addr;

    assign unused_addr = ^wb_addr[31:ADDR_BITS+1];

    // A zero-wait access commits on the same edge it is sampled, so it uses
    // the live bus; later commits use the values latched in IDLE.
    assign req      = wb_cyc & wb_stb;
    assign idle     = state_q == IDLE;
    assign acc_addr = idle ? wb_addr[ADDR_BITS:0] : addr_q;
    assign acc_we   = idle ? wb_we : we_q;
    assign acc_dat  = idle ? wb_data_i : dat_q;
    assign acc_sel  = idle ? wb_bwsel : sel_q;
    assign go_ack   = req & (idle ? wcfg_q == 4'd0 : state_q == WAIT && cnt_q == 4'd1);
    assign is_ctrl  = acc_addr[ADDR_BITS];
    assign ram_idx  = acc_addr[ADDR_BITS-1:0];
    assign reg_sel  = acc_addr[1:0];
    assign ram_wr   = go_ack & acc_we & ~is_ctrl;
    assign ram_rd   = go_ack & ~acc_we & ~is_ctrl;
    assign ctrl_val = reg_sel == 2'd0 ? ID_VALUE :
                      reg_sel == 2'd1 ? {28'd0, wcfg_q} :
                      reg_sel == 2'd2 ? wr_cnt_q : rd_cnt_q;
    assign rd_val   = is_ctrl ? ctrl_val : mem[ram_idx];

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: if (req) begin
                addr_d  = wb_addr[ADDR_BITS:0];
                we_d    = wb_we;
                dat_d   = wb_data_i;
                sel_d   = wb_bwsel;
                cnt_d   = wcfg_q;
                state_d = wcfg_q != 4'd0 ? WAIT : ACK;
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = !req ? IDLE : cnt_q == 4'd1 ? ACK : WAIT;
            end
            ACK:  state_d = DONE;
            DONE: state_d = req ? DONE : IDLE;
        endcase
        ack_d    = go_ack;
        rdata_d  = go_ack && !acc_we ? rd_val : 32'd0;
        wcfg_d   = go_ack && acc_we && is_ctrl && reg_sel == 2'd1 && acc_sel[0] ? acc_dat[3:0] : wcfg_q;
        wr_cnt_d = go_ack && acc_we && is_ctrl && reg_sel == 2'd2 ? 32'd0 :
                   ram_wr ? wr_cnt_q + 32'd1 : wr_cnt_q;
        rd_cnt_d = go_ack && acc_we && is_ctrl && reg_sel == 2'd3 ? 32'd0 :
                   ram_rd ? rd_cnt_q + 32'd1 : rd_cnt_q;
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            dat_q    <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
            wcfg_q   <= WAIT_RST;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            wcfg_q   <= wcfg_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
        end
    end

    // Gated by reset so an access held on the bus during reset never lands.
    always_ff @(posedge wb_clk) begin
        if (ram_wr && wb_rst_n)
            for (int i = 0; i < 4; i++)
                if (acc_sel[i]) mem[ram_idx][8*i +: 8] <= acc_dat[8*i +: 8];
    end

    assign wb_ack    = ack_q;
    assign wb_data_o = rdata_q;
endmodule

// File: tb/tb_wb_test_slave.sv
// tb_wb_test_slave: directed Wishbone master exercising RAM lanes, wait
// states, stb hold, aborts, counters and mid-access reset.
module tb_wb_test_slave;
    logic        wb_clk = 1'b0;
    logic        wb_rst_n = 1'b1;
    logic [31:0] wb_addr = '0;
    logic [31:0] wb_data_i = '0;
    logic [31:0] wb_data_o;
    logic [3:0]  wb_bwsel = '0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_we = 1'b0;
    logic        wb_ack;

    int checks = 0;
    int errors = 0;

    wb_test_slave dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .wb_addr(wb_addr),
        .wb_data_i(wb_data_i), .wb_data_o(wb_data_o), .wb_bwsel(wb_bwsel),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_ack(wb_ack)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] sel, input int hold,
                       output logic [31:0] rdata, output int lat, output int extra);
        @(posedge wb_clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_addr = addr; wb_data_i = data; wb_bwsel = sel;
        lat = 0; extra = 0;
        do begin
            @(posedge wb_clk); #1;
            lat++;
        end while (!wb_ack && lat < 40);
        if (!wb_ack) check("ack_timeout", {31'd0, wb_ack}, 32'd1);
        rdata = wb_data_o;
        repeat (hold) begin
            @(posedge wb_clk); #1;
            if (wb_ack) extra++;
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge wb_clk); #1;
        check("ack_width", {31'd0, wb_ack}, 32'd0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
        logic [31:0] d;
        int l, e;
        bus(1'b1, addr, data, sel, 0, d, l, e);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        int l, e;
        bus(1'b0, addr, 32'd0, 4'h1, 0, d, l, e);
        check(tag, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        int lat, extra, acks;
        #2 wb_rst_n = 1'b0;
        #1;
        check("rst_ack", {31'd0, wb_ack}, 32'd0);
        check("rst_data", wb_data_o, 32'd0);
        repeat (2) @(posedge wb_clk);
        #1 wb_rst_n = 1'b1;

        rd_chk("id", 32'h100, 32'h05B5_0001);
        rd_chk("wait_rst", 32'h101, 32'd0);
        rd_chk("wrcnt_rst", 32'h102, 32'd0);
        rd_chk("rdcnt_rst", 32'h103, 32'd0);

        wr(32'd5, 32'hDEADBEEF, 4'hF);
        rd_chk("ram_w32", 32'd5, 32'hDEADBEEF);
        check("idle_data", wb_data_o, 32'd0);
        wr(32'd5, 32'h11223344, 4'b1000);
        rd_chk("ram_lane3", 32'd5, 32'h11ADBEEF);
        wr(32'd5, 32'h55662233, 4'b0011);
        rd_chk("ram_lane01", 32'd5, 32'h11AD2233);
        wr(32'd5, 32'hFFFFFFFF, 4'b0000);
        rd_chk("ram_sel0", 32'd5, 32'h11AD2233);
        rd_chk("wrcnt4", 32'h102, 32'd4);
        rd_chk("rdcnt4", 32'h103, 32'd4);

        bus(1'b0, 32'd5, 32'd0, 4'hF, 0, d, lat, extra);
        check("lat_w0", lat, 32'd1);
        wr(32'h101, 32'd3, 4'b0001);
        rd_chk("wait_set3", 32'h101, 32'd3);
        bus(1'b0, 32'd5, 32'd0, 4'hF, 0, d, lat, extra);
        check("lat_w3", lat, 32'd4);
        check("lat_w3_data", d, 32'h11AD2233);
        wr(32'h101, 32'h0000000F, 4'b1110);
        rd_chk("wait_nosel", 32'h101, 32'd3);
        wr(32'h101, 32'hFFFFFFF7, 4'b0001);
        rd_chk("wait_mask", 32'h101, 32'd7);
        wr(32'h101, 32'd0, 4'b0001);
        rd_chk("alias_id", 32'hABCD_0300, 32'h05B5_0001);

        bus(1'b1, 32'd7, 32'h12345678, 4'hF, 2, d, lat, extra);
        check("hold_extra", extra, 32'd0);
        rd_chk("hold_wrcnt", 32'h102, 32'd5);

        wr(32'h101, 32'd5, 4'b0001);
        @(posedge wb_clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_addr = 32'd7; wb_data_i = 32'h0; wb_bwsel = 4'hF;
        acks = 0;
        repeat (2) begin @(posedge wb_clk); #1; if (wb_ack) acks++; end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        repeat (8) begin @(posedge wb_clk); #1; if (wb_ack) acks++; end
        check("abort_ack", acks, 32'd0);
        wr(32'h101, 32'd0, 4'b0001);
        rd_chk("abort_wrcnt", 32'h102, 32'd5);
        rd_chk("abort_rdcnt", 32'h103, 32'd6);
        rd_chk("abort_ram", 32'd7, 32'h12345678);

        wr(32'h102, 32'd0, 4'b0000);
        wr(32'h103, 32'd0, 4'b0000);
        rd_chk("clr_wr", 32'h102, 32'd0);
        rd_chk("clr_rd", 32'h103, 32'd0);
        wr(32'd10, 32'h10101010, 4'hF);
        wr(32'd11, 32'h11111111, 4'hF);
        wr(32'd12, 32'h12121212, 4'hF);
        rd_chk("ram10", 32'd10, 32'h10101010);
        rd_chk("ram11", 32'd11, 32'h11111111);
        rd_chk("cnt_wr3", 32'h102, 32'd3);
        rd_chk("cnt_rd2", 32'h103, 32'd2);
        wr(32'h102, 32'hFFFFFFFF, 4'hF);
        rd_chk("wrclr_wr", 32'h102, 32'd0);
        rd_chk("wrclr_rd", 32'h103, 32'd2);

        wr(32'h101, 32'd5, 4'b0001);
        @(posedge wb_clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_addr = 32'd10; wb_data_i = 32'hFFFFFFFF; wb_bwsel = 4'hF;
        acks = 0;
        repeat (2) begin @(posedge wb_clk); #1; if (wb_ack) acks++; end
        wb_rst_n = 1'b0;
        repeat (3) begin @(posedge wb_clk); #1; if (wb_ack) acks++; end
        check("rst_mid_data", wb_data_o, 32'd0);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_rst_n = 1'b1;
        repeat (6) begin @(posedge wb_clk); #1; if (wb_ack) acks++; end
        check("rst_mid_ack", acks, 32'd0);
        rd_chk("rst_mid_wait", 32'h101, 32'd0);
        rd_chk("rst_mid_wr", 32'h102, 32'd0);
        rd_chk("rst_mid_rd", 32'h103, 32'd0);
        rd_chk("rst_mid_ram", 32'd10, 32'h10101010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
